wasca_spi_slave: RTL

WASCA_SPI_SLAVE -- requirements
Module: wasca_spi_slave

---
 rtl/wasca_spi_slave.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/wasca_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module      : wasca_spi_slave
//  Description : SPI mode-0 byte slave (8 bit, MSB first) with a CPU-side
//                register port. SPI pins are oversampled in the clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module wasca_spi_slave #(
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  // SPI bus from the external master
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  // CPU slave port
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  localparam logic [2:0] c_ADDR_RX     = 3'd0;
  localparam logic [2:0] c_ADDR_TX     = 3'd1;
  localparam logic [2:0] c_ADDR_STATUS = 3'd2;
  localparam logic [2:0] c_ADDR_CTRL   = 3'd3;

  // synchronizer stages (stage 3 is only used for edge detection)
  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_ss_s1, r_ss_s2, r_ss_s3;
  logic r_mosi_s1, r_mosi_s2;

  // serial datapath
  logic [2:0] r_bitcnt;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_holding;
  logic [7:0] r_tx_shift;
  logic [7:0] r_tx_holding;
  logic       r_tx_primed;

  // flags and control
  logic       r_rrdy, r_roe, r_toe, r_und;
  logic [5:0] r_ctrl;            // {iE, iRRDY, iTRDY, iUND, iTOE, iROE}

  // CPU access tracking
  logic r_rd_strobe, r_wr_strobe, r_rx_read;

  logic       w_sel, w_sclk_rise, w_sclk_fall, w_ss_fall, w_ss_rise;
  logic       w_rise_act, w_fall_act, w_byte_done;
  logic       w_tx_load, w_tx_shift_en;
  logic [7:0] w_next_byte;
  logic       w_p1_rd, w_p1_wr;
  logic       w_wr_tx, w_status_clr, w_wr_ctrl;
  logic       w_primed_after_load, w_tx_accept, w_toe_set;
  logic       w_trdy, w_e;
  logic [15:0] w_status, w_control, w_rd_mux;
  logic       w_unused;

  // ---------------------------------------------------------------- edges
  assign w_sel        = ~r_ss_s2;
  assign w_sclk_rise  =  r_sclk_s2 & ~r_sclk_s3;
  assign w_sclk_fall  = ~r_sclk_s2 &  r_sclk_s3;
  assign w_ss_fall    = ~r_ss_s2   &  r_ss_s3;
  assign w_ss_rise    =  r_ss_s2   & ~r_ss_s3;
  assign w_rise_act   = w_sclk_rise & w_sel;
  assign w_fall_act   = w_sclk_fall & w_sel;
  assign w_byte_done  = w_rise_act & (r_bitcnt == 3'd7);

  // A fresh byte enters tx_shift at select and after every completed byte.
  assign w_tx_load     = w_ss_fall | (w_fall_act & (r_bitcnt == 3'd0));
  assign w_tx_shift_en = w_fall_act & (r_bitcnt != 3'd0);
  assign w_next_byte   = r_tx_primed ? r_tx_holding : FILL_BYTE;

  // ------------------------------------------------------------ CPU side
  assign w_p1_rd      = spi_select & ~read_n  & ~r_rd_strobe;
  assign w_p1_wr      = spi_select & ~write_n & ~r_wr_strobe;
  assign w_wr_tx      = w_p1_wr & (mem_addr == c_ADDR_TX);
  assign w_status_clr = w_p1_wr & (mem_addr == c_ADDR_STATUS);
  assign w_wr_ctrl    = w_p1_wr & (mem_addr == c_ADDR_CTRL);

  // A tx write landing on the same cycle as a load sees the holding
  // register already emptied by that load.
  assign w_primed_after_load = r_tx_primed & ~w_tx_load;
  assign w_tx_accept         = w_wr_tx & ~w_primed_after_load;
  assign w_toe_set           = w_wr_tx &  w_primed_after_load;

  assign w_trdy    = ~r_tx_primed;
  assign w_e       = r_roe | r_toe | r_und;
  assign w_status  = {6'b0, w_sel, w_e, r_rrdy, w_trdy, r_und, r_toe, r_roe, 3'b0};
  assign w_control = {7'b0, r_ctrl, 3'b0};

  assign MISO          = r_tx_shift[7];
  assign MISO_oe       = w_sel;
  assign dataavailable = r_rrdy;
  assign readyfordata  = w_trdy;
  assign w_unused      = ^data_from_cpu[15:9];

  // Read data selection for the registered CPU read path.
  always_comb begin
    w_rd_mux = 16'h0000;
    case (mem_addr)
      c_ADDR_RX:     w_rd_mux = {8'h00, r_rx_holding};
      c_ADDR_STATUS: w_rd_mux = w_status;
      c_ADDR_CTRL:   w_rd_mux = w_control;
      default:       w_rd_mux = 16'h0000;
    endcase
  end

  // Two-flop synchronizers plus one extra stage for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_s3 <= 1'b0;
      r_ss_s1   <= 1'b1; r_ss_s2   <= 1'b1; r_ss_s3   <= 1'b1;
      r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= SCLK;      r_sclk_s2 <= r_sclk_s1; r_sclk_s3 <= r_sclk_s2;
      r_ss_s1   <= SS_n;      r_ss_s2   <= r_ss_s1;   r_ss_s3   <= r_ss_s2;
      r_mosi_s1 <= MOSI;      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Receive shifter and bit counter; deselect aborts a partial byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (w_ss_rise) begin
      r_bitcnt   <= 3'd0;
      r_rx_shift <= 8'h00;
    end else if (w_rise_act) begin
      r_bitcnt   <= r_bitcnt + 3'd1;
      r_rx_shift <= {r_rx_shift[6:0], r_mosi_s2};
    end
  end

  // Receive holding register with RRDY / ROE; a completing byte beats a read clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_holding <= 8'h00;
      r_rrdy       <= 1'b0;
      r_roe        <= 1'b0;
    end else begin
      if (w_status_clr)
        r_roe <= 1'b0;
      if (w_byte_done) begin
        r_rx_holding <= {r_rx_shift[6:0], r_mosi_s2};
        r_rrdy       <= 1'b1;
        if (r_rrdy)
          r_roe <= 1'b1;
      end else if (r_rx_read) begin
        r_rrdy <= 1'b0;
      end
    end
  end

  // Transmit shifter, holding register and TOE / UND flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_shift   <= 8'h00;
      r_tx_holding <= 8'h00;
      r_tx_primed  <= 1'b0;
      r_toe        <= 1'b0;
      r_und        <= 1'b0;
    end else begin
      if (w_tx_load)
        r_tx_shift <= w_next_byte;
      else if (w_tx_shift_en)
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};

      if (w_tx_accept) begin
        r_tx_holding <= data_from_cpu[7:0];
        r_tx_primed  <= 1'b1;
      end else if (w_tx_load) begin
        r_tx_primed  <= 1'b0;
      end

      if (w_status_clr) begin
        r_toe <= 1'b0;
        r_und <= 1'b0;
      end
      if (w_toe_set)
        r_toe <= 1'b1;
      if (w_tx_load && !r_tx_primed)
        r_und <= 1'b1;
    end
  end

  // Interrupt enable register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_ctrl <= 6'd0;
    else if (w_wr_ctrl)
      r_ctrl <= data_from_cpu[8:3];
  end

  // Single-pulse strobes for two-cycle CPU accesses; rx read clears RRDY a cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_strobe <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_rx_read   <= 1'b0;
    end else begin
      r_rd_strobe <= spi_select & ~read_n;
      r_wr_strobe <= spi_select & ~write_n;
      r_rx_read   <= w_p1_rd & (mem_addr == c_ADDR_RX);
    end
  end

  // Registered read data and interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_to_cpu <= 16'h0000;
      irq         <= 1'b0;
    end else begin
      data_to_cpu <= w_rd_mux;
      irq <= (r_rrdy & r_ctrl[4]) | (w_trdy & r_ctrl[3]) | (r_roe & r_ctrl[0]) |
             (r_toe  & r_ctrl[1]) | (r_und  & r_ctrl[2]) | (w_e   & r_ctrl[5]);
    end
  end

endmodule
`default_nettype wire
